inta_sequencer: RTL and testbench

- CPU-side end of the PIC interrupt path.
- Consumes the masked request vector produced by the interrupt request register and raises INT to the CPU.
- Runs the 8086-style two-pulse INTA handshake, maintains the in-service register (ISR) and drives the interrupt vector onto the data bus.
- Pulses a per-level clear back to the request register so edge-latched requests are consumed once acknowledged.

---
 rtl/inta_sequencer_pkg.sv | 34 +++
 rtl/pic_priority_resolver.sv | 28 ++
 rtl/inta_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_inta_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inta_sequencer_pkg.sv
// Shared PIC definitions: handshake state codes, level count and a
// lowest-set-bit helper used for priority and non-specific EOI.
package inta_sequencer_pkg;

  localparam int unsigned NUM_LEVELS = 8;

  // INTA handshake states
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StAck1 = 3'd2;
  localparam logic [2:0] StGap  = 3'd3;
  localparam logic [2:0] StAck2 = 3'd4;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } lowest_t;

  // Lowest-index set bit of vec; valid=0 when vec is all zero.
  function automatic lowest_t lowest_set(input logic [NUM_LEVELS-1:0] vec);
    lowest_t r;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_LEVELS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fully-nested fixed-priority resolver: picks the highest-priority request
// that outranks everything currently in service (bit 0 highest).
module pic_priority_resolver
  import inta_sequencer_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic       cand_valid,
  output logic [2:0] cand_level
);

  lowest_t    isr_low;
  lowest_t    cand;
  logic [7:0] eligible;

  // Requests strictly above the highest-priority in-service level are eligible.
  always_comb begin
    isr_low  = lowest_set(isr);
    eligible = '0;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
      eligible[i] = !isr_low.valid || (3'(i) < isr_low.idx);
    end
    cand       = lowest_set(irr & eligible);
    cand_valid = cand.valid;
    cand_level = cand.idx;
  end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side end of the PIC: raises INT, runs the two-pulse INTA handshake,
// keeps the in-service register and drives the vector byte.
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic [2:0]  SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic       inta_n,
  input  logic [4:0] icw2_base,
  input  logic       aeoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clr_irr,
  output logic [7:0] data_out,
  output logic       data_oe
);

  logic       inta_s;
  logic       inta_prev_q;
  logic       inta_fall;
  logic       inta_rise;

  logic [2:0] state_q, state_d;
  logic       int_q, int_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] clr_q, clr_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_q, oe_d;
  logic [2:0] level_q, level_d;
  logic       spur_q, spur_d;

  logic       cand_valid;
  logic [2:0] cand_level;
  lowest_t    isr_low;
  logic [7:0] eoi_clr;
  logic [7:0] aeoi_clr;
  logic [7:0] isr_set;

  // inta_n synchroniser; idles high so reset never produces a false edge
  if (SYNC_STAGES == 0) begin : g_nosync
    assign inta_s = inta_n;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the pin through SYNC_STAGES flops
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_q <= '1;
      end else begin
        sync_q[0] <= inta_n;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign inta_s = sync_q[SYNC_STAGES-1];
  end

  // Last synchronised inta_n value for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      inta_prev_q <= 1'b1;
    end else begin
      inta_prev_q <= inta_s;
    end
  end

  assign inta_fall = inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q & inta_s;

  pic_priority_resolver u_resolver (
    .irr        (irr),
    .isr        (isr_q),
    .cand_valid (cand_valid),
    .cand_level (cand_level)
  );

  // EOI clear mask, computed on the pre-update ISR
  always_comb begin
    isr_low = lowest_set(isr_q);
    eoi_clr = '0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_clr = 8'b1 << eoi_level;
      end else if (isr_low.valid) begin
        eoi_clr = 8'b1 << isr_low.idx;
      end
    end
  end

  // Handshake next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    level_d  = level_q;
    spur_d   = spur_q;
    clr_d    = '0;
    isr_set  = '0;
    aeoi_clr = '0;

    case (state_q)
      StIdle: begin
        if (cand_valid) begin
          state_d = StReq;
          int_d   = 1'b1;
        end
      end
      StReq: begin
        // int_out is held even if the request goes away; it resolves at INTA.
        if (inta_fall) begin
          state_d = StAck1;
          int_d   = 1'b0;
          if (cand_valid) begin
            level_d = cand_level;
            spur_d  = 1'b0;
            isr_set = 8'b1 << cand_level;
            clr_d   = 8'b1 << cand_level;
          end else begin
            level_d = SPURIOUS_LEVEL;
            spur_d  = 1'b1;
          end
        end
      end
      StAck1: begin
        oe_d = 1'b0;
        if (inta_rise) begin
          state_d = StGap;
        end
      end
      StGap: begin
        if (inta_fall) begin
          state_d = StAck2;
          oe_d    = 1'b1;
          dout_d  = {icw2_base, level_q};
        end
      end
      StAck2: begin
        if (inta_rise) begin
          state_d = StIdle;
          oe_d    = 1'b0;
          if (aeoi && !spur_q) begin
            aeoi_clr = 8'b1 << level_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
        int_d   = 1'b0;
        oe_d    = 1'b0;
      end
    endcase

    // Clears first, then the set, so a same-cycle set on the same bit wins.
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      int_q   <= 1'b0;
      isr_q   <= '0;
      clr_q   <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      level_q <= 3'd0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      isr_q   <= isr_d;
      clr_q   <= clr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      level_q <= level_d;
      spur_q  <= spur_d;
    end
  end

  assign int_out  = int_q;
  assign isr      = isr_q;
  assign clr_irr  = clr_q;
  assign data_out = dout_q;
  assign data_oe  = oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: behavioural handshake model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_inta_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr;
  logic       inta_n;
  logic [4:0] icw2_base;
  logic       aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clr_irr;
  logic [7:0] data_out;
  logic       data_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inta_sequencer #(
    .SYNC_STAGES    (SYNC),
    .SPURIOUS_LEVEL (3'd7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irr          (irr),
    .inta_n       (inta_n),
    .icw2_base    (icw2_base),
    .aeoi         (aeoi),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .int_out      (int_out),
    .isr          (isr),
    .clr_irr      (clr_irr),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       model_ok = 1'b0;
  logic       m_int, m_oe, m_busy, m_spur;
  logic [7:0] m_isr, m_clr, m_vec, nisr;
  logic [2:0] m_level;
  int         m_edges;    // detected INTA edges in the current handshake
  logic       hist [1:SYNC+1];  // inta_n sampled i edges ago
  logic       seq  [0:SYNC+1];
  logic       s_now, s_prev, mfall, mrise;
  int         lim, cidx;

  always @(posedge clk) begin
    seq[0] = inta_n;
    for (int i = 1; i <= SYNC + 1; i++) seq[i] = hist[i];
    s_now  = seq[SYNC];
    s_prev = seq[SYNC+1];
    mfall  = s_prev && !s_now;
    mrise  = !s_prev && s_now;
    if (reset) begin
      m_int = 0; m_oe = 0; m_busy = 0; m_spur = 0;
      m_isr = 0; m_clr = 0; m_vec = 0; m_level = 0; m_edges = 0;
      for (int i = 1; i <= SYNC + 1; i++) hist[i] = 1'b1;
    end else begin
      lim = 8;
      for (int i = 7; i >= 0; i--) if (m_isr[i]) lim = i;
      cidx = -1;
      for (int i = 7; i >= 0; i--) if (irr[i] && i < lim) cidx = i;
      nisr  = m_isr;
      m_clr = 0;
      if (eoi_valid) begin
        if (eoi_specific) nisr[eoi_level] = 1'b0;
        else nisr = m_isr & (m_isr - 8'd1);
      end
      if (!m_busy) begin
        if (cidx >= 0) begin
          m_busy = 1; m_edges = 0; m_int = 1;
        end
      end else if (m_edges == 0 && mfall) begin
        m_edges = 1; m_int = 0;
        if (cidx >= 0) begin
          m_level = 3'(cidx); m_spur = 0;
          nisr[cidx] = 1'b1;
          m_clr = 8'd1 << cidx;
        end else begin
          m_level = 3'd7; m_spur = 1;
        end
      end else if (m_edges == 1 && mrise) begin
        m_edges = 2;
      end else if (m_edges == 2 && mfall) begin
        m_edges = 3; m_oe = 1; m_vec = {icw2_base, m_level};
      end else if (m_edges == 3 && mrise) begin
        m_busy = 0; m_oe = 0;
        if (aeoi && !m_spur) nisr[m_level] = 1'b0;
      end
      m_isr = nisr;
      for (int i = SYNC + 1; i >= 2; i--) hist[i] = hist[i-1];
      hist[1] = inta_n;
    end
    model_ok = 1'b1;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_int_out", {7'd0, int_out}, {7'd0, m_int});
      chk("m_isr", isr, m_isr);
      chk("m_clr_irr", clr_irr, m_clr);
      chk("m_data_oe", {7'd0, data_oe}, {7'd0, m_oe});
      if (m_oe) chk("m_data_out", data_out, m_vec);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One INTA pulse; reports how many cycles clr_irr was non-zero and its OR.
  task automatic pulse(output int clr_cyc, output logic [7:0] clr_or);
    clr_cyc = 0;
    clr_or  = 0;
    inta_n  = 1'b0;
    for (int i = 0; i < SYNC + 3; i++) begin
      @(negedge clk);
      if (clr_irr != 0) clr_cyc++;
      clr_or |= clr_irr;
    end
    inta_n = 1'b1;
    for (int i = 0; i < SYNC + 3; i++) begin
      @(negedge clk);
      if (clr_irr != 0) clr_cyc++;
      clr_or |= clr_irr;
    end
  endtask

  task automatic wait_int(input string name);
    for (int i = 0; i < 6 && int_out !== 1'b1; i++) @(negedge clk);
    chk(name, {7'd0, int_out}, 8'd1);
  endtask

  // Second INTA pulse, checking the vector while the bus is driven.
  task automatic pulse2(input string name, input logic [7:0] vec);
    inta_n = 1'b0;
    for (int i = 0; i < SYNC + 6 && data_oe !== 1'b1; i++) @(negedge clk);
    chk({name, "_oe"}, {7'd0, data_oe}, 8'd1);
    chk({name, "_vec"}, data_out, vec);
    tick(2);
    inta_n = 1'b1;
    tick(SYNC + 3);
    chk({name, "_oe_off"}, {7'd0, data_oe}, 8'd0);
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl;
    tick(1);
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    tick(1);
  endtask

  int         cc;
  logic [7:0] co;

  initial begin
    reset = 1'b1; irr = 0; inta_n = 1'b1; icw2_base = 5'h10; aeoi = 0;
    eoi_valid = 0; eoi_specific = 0; eoi_level = 0;
    tick(3);
    chk("rst_int", {7'd0, int_out}, 8'd0);
    chk("rst_isr", isr, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_oe", {7'd0, data_oe}, 8'd0);
    reset = 1'b0;
    tick(2);

    // Single request at level 3
    irr = 8'h08;
    wait_int("single_int");
    pulse(cc, co);
    irr = 0;
    chk("single_isr", isr, 8'h08);
    chk("single_clr_or", co, 8'h08);
    chk("single_clr_cyc", 8'(cc), 8'd1);
    chk("single_int_low", {7'd0, int_out}, 8'd0);
    pulse2("single", 8'h83);
    eoi(1'b0, 3'd0);
    chk("single_eoi", isr, 8'h00);

    // Nesting: level 4 in service, level 2 preempts, level 5 blocked
    irr = 8'h10;
    wait_int("nest_a_int");
    pulse(cc, co);
    irr = 0;
    pulse2("nest_a", 8'h84);
    chk("nest_a_isr", isr, 8'h10);
    irr = 8'h24;
    wait_int("nest_b_int");
    pulse(cc, co);
    irr = 8'h20;
    pulse2("nest_b", 8'h82);
    chk("nest_b_isr", isr, 8'h14);
    tick(4);
    chk("nest_blocked", {7'd0, int_out}, 8'd0);
    irr = 0;
    eoi(1'b0, 3'd0);
    chk("nest_eoi1", isr, 8'h10);
    eoi(1'b0, 3'd0);
    chk("nest_eoi2", isr, 8'h00);

    // Spurious: request withdrawn before first INTA
    irr = 8'h01;
    wait_int("spur_int");
    irr = 0;
    tick(2);
    chk("spur_int_held", {7'd0, int_out}, 8'd1);
    pulse(cc, co);
    chk("spur_clr_cyc", 8'(cc), 8'd0);
    chk("spur_isr", isr, 8'h00);
    pulse2("spur", 8'h87);

    // Automatic EOI at level 6
    aeoi = 1'b1;
    irr = 8'h40;
    wait_int("aeoi_int");
    pulse(cc, co);
    irr = 0;
    chk("aeoi_isr_set", isr, 8'h40);
    pulse2("aeoi", 8'h86);
    chk("aeoi_isr_clr", isr, 8'h00);
    aeoi = 1'b0;

    // Specific EOI on level 1 in the same cycle as the set of level 0
    irr = 8'h02;
    wait_int("sp_a_int");
    pulse(cc, co);
    irr = 0;
    pulse2("sp_a", 8'h81);
    chk("sp_a_isr", isr, 8'h02);
    irr = 8'h01;
    wait_int("sp_b_int");
    inta_n = 1'b0;
    tick(SYNC);
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1;
    tick(1);
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    tick(2);
    inta_n = 1'b1;
    tick(SYNC + 3);
    irr = 0;
    chk("sp_b_isr", isr, 8'h01);
    pulse2("sp_b", 8'h80);
    eoi(1'b0, 3'd0);
    chk("sp_b_eoi", isr, 8'h00);

    // Reset in the middle of the second INTA pulse
    icw2_base = 5'h0a;
    irr = 8'h08;
    wait_int("rst_mid_int");
    pulse(cc, co);
    inta_n = 1'b0;
    for (int i = 0; i < SYNC + 6 && data_oe !== 1'b1; i++) @(negedge clk);
    chk("rst_mid_oe", {7'd0, data_oe}, 8'd1);
    chk("rst_mid_vec", data_out, 8'h53);
    reset = 1'b1; irr = 0; inta_n = 1'b1;
    tick(1);
    chk("rst_mid_oe_off", {7'd0, data_oe}, 8'd0);
    chk("rst_mid_int_off", {7'd0, int_out}, 8'd0);
    chk("rst_mid_isr", isr, 8'h00);
    reset = 1'b0;
    tick(4);
    chk("rst_mid_idle", {7'd0, int_out}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
